// File: rtl/otter_pipe_track.sv
// otter_pipe_track: pipeline register chain plus scoreboard between decode
// and writeback. Stage 0 = EX, stage STAGES-1 = WB.
//
// Ports:
//   CLK, RESET            clock, synchronous active-low reset
//   in_*                  instruction presented by decode
//   in_ready              instruction accepted this cycle (combinational)
//   freeze, flush         hold all stages / kill the youngest FLUSH_STAGES
//   st_valid, st_data     per-stage valid and payload (stage i at i*DATA_W)
//   wb_valid/rd/rd_used   last-stage view for the register file write
//   fwd_sel1, fwd_sel2    forward source (0 = regfile, k = stage k-1)
//   stall_cnt, bubble_cnt, flush_cnt
//                         saturating perf counters, present only when
//                         OTTER_PIPE_PERF_EN is defined
module otter_pipe_track #(
    parameter int STAGES       = 4,
    parameter int DATA_W       = 64,
    parameter int REG_AW       = 5,
    parameter int FLUSH_STAGES = 1
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [REG_AW-1:0]            in_rd,
    input  logic                         in_rd_used,
    input  logic                         in_is_load,
    input  logic [REG_AW-1:0]            in_rs1,
    input  logic [REG_AW-1:0]            in_rs2,
    input  logic                         in_rs1_used,
    input  logic                         in_rs2_used,
    output logic                         in_ready,
    input  logic                         freeze,
    input  logic                         flush,
    output logic [STAGES-1:0]            st_valid,
    output logic [STAGES*DATA_W-1:0]     st_data,
    output logic                         wb_valid,
    output logic [REG_AW-1:0]            wb_rd,
    output logic                         wb_rd_used,
    output logic [$clog2(STAGES+1)-1:0]  fwd_sel1,
    output logic [$clog2(STAGES+1)-1:0]  fwd_sel2
`ifdef OTTER_PIPE_PERF_EN
    ,
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  bubble_cnt,
    output logic [31:0]                  flush_cnt
`endif
);

    localparam int FW = $clog2(STAGES+1);

    logic              valid_q   [STAGES];
    logic              valid_d   [STAGES];
    logic [DATA_W-1:0] data_q    [STAGES];
    logic [DATA_W-1:0] data_d    [STAGES];
    logic [REG_AW-1:0] rd_q      [STAGES];
    logic [REG_AW-1:0] rd_d      [STAGES];
    logic              rd_used_q [STAGES];
    logic              rd_used_d [STAGES];
    logic              is_load_q [STAGES];
    logic              is_load_d [STAGES];

    logic hazard;
    logic accept;

    // Load in EX whose result a decode source needs: hold decode one cycle.
    always_comb begin
        hazard = 1'b0;
        if (in_valid && valid_q[0] && is_load_q[0] &&
            rd_used_q[0] && (rd_q[0] != '0)) begin
            hazard = (in_rs1_used && (in_rs1 == rd_q[0])) ||
                     (in_rs2_used && (in_rs2 == rd_q[0]));
        end
    end

    assign in_ready = ~freeze & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            valid_d[i]   = valid_q[i];
            data_d[i]    = data_q[i];
            rd_d[i]      = rd_q[i];
            rd_used_d[i] = rd_used_q[i];
            is_load_d[i] = is_load_q[i];
        end
        if (!freeze) begin
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i]   = valid_q[i-1];
                data_d[i]    = data_q[i-1];
                rd_d[i]      = rd_q[i-1];
                rd_used_d[i] = rd_used_q[i-1];
                is_load_d[i] = is_load_q[i-1];
            end
            if (accept) begin
                valid_d[0]   = 1'b1;
                data_d[0]    = in_data;
                rd_d[0]      = in_rd;
                rd_used_d[0] = in_rd_used;
                is_load_d[0] = in_is_load;
            end else begin
                // Bubble: payload and rd are left as they were.
                valid_d[0]   = 1'b0;
                rd_used_d[0] = 1'b0;
                is_load_d[0] = 1'b0;
            end
        end
        // Flush overrides freeze for the youngest stages only.
        if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                if (i < FLUSH_STAGES) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i]   <= 1'b0;
                data_q[i]    <= '0;
                rd_q[i]      <= '0;
                rd_used_q[i] <= 1'b0;
                is_load_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i]   <= valid_d[i];
                data_q[i]    <= data_d[i];
                rd_q[i]      <= rd_d[i];
                rd_used_q[i] <= rd_used_d[i];
                is_load_q[i] <= is_load_d[i];
            end
        end
    end

    // Scan oldest to youngest so the youngest match wins. A load in EX is
    // skipped: its data does not exist yet and the hazard logic stalls.
    always_comb begin
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        for (int k = STAGES-1; k >= 0; k--) begin
            if (valid_q[k] && rd_used_q[k] &&
                !((k == 0) && is_load_q[0])) begin
                if (rd_q[k] == in_rs1) fwd_sel1 = FW'(k + 1);
                if (rd_q[k] == in_rs2) fwd_sel2 = FW'(k + 1);
            end
        end
        if (in_rs1 == '0) fwd_sel1 = '0;
        if (in_rs2 == '0) fwd_sel2 = '0;
    end

    always_comb begin
        st_data = '0;
        for (int i = 0; i < STAGES; i++) begin
            st_valid[i]                = valid_q[i];
            st_data[i*DATA_W +: DATA_W] = data_q[i];
        end
    end

    assign wb_valid   = valid_q[STAGES-1];
    assign wb_rd      = valid_q[STAGES-1] ? rd_q[STAGES-1] : '0;
    assign wb_rd_used = valid_q[STAGES-1] & rd_used_q[STAGES-1];

`ifdef OTTER_PIPE_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] bubble_q, bubble_d;
    logic [31:0] flush_q, flush_d;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        flush_d  = flush_q;
        if (freeze && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        if (hazard && !freeze && (bubble_q != '1)) begin
            bubble_d = bubble_q + 32'd1;
        end
        if (flush && (flush_q != '1)) begin
            flush_d = flush_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
            flush_q  <= flush_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
    assign flush_cnt  = flush_q;
`endif

endmodule

// File: tb/tb_otter_pipe_track.sv
// tb_otter_pipe_track: vector table plus writeback scoreboard for
// otter_pipe_track (STAGES=4, FLUSH_STAGES=2).
module tb_otter_pipe_track;

    localparam int S  = 4;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int FS = 2;
    localparam int FW = $clog2(S+1);

    logic          CLK = 1'b0;
    logic          RESET;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_rd;
    logic          in_rd_used;
    logic          in_is_load;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic          in_rs1_used;
    logic          in_rs2_used;
    logic          in_ready;
    logic          freeze;
    logic          flush;
    logic [S-1:0]    st_valid;
    logic [S*DW-1:0] st_data;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic          wb_rd_used;
    logic [FW-1:0] fwd_sel1;
    logic [FW-1:0] fwd_sel2;
`ifdef OTTER_PIPE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;
`endif

    otter_pipe_track #(
        .STAGES(S), .DATA_W(DW), .REG_AW(AW), .FLUSH_STAGES(FS)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_data(in_data),
        .in_rd(in_rd), .in_rd_used(in_rd_used),
        .in_is_load(in_is_load),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
        .in_ready(in_ready), .freeze(freeze), .flush(flush),
        .st_valid(st_valid), .st_data(st_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_used(wb_rd_used),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2)
`ifdef OTTER_PIPE_PERF_EN
        ,
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic [AW-1:0] rd;
        logic          rdu;
        logic          ld;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic          u1;
        logic          u2;
        logic          rdy;
        logic [FW-1:0] f1;
        logic [FW-1:0] f2;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] rd;
        logic          rdu;
        int            t;
    } sb_t;

    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    bit  mon_en = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(int v, int d, int rd, int rdu, int ld,
                                int r1, int r2, int u1, int u2,
                                int rdy, int f1, int f2);
        vec_t r;
        r.v   = 1'(v);
        r.d   = 64'(d);
        r.rd  = AW'(rd);
        r.rdu = 1'(rdu);
        r.ld  = 1'(ld);
        r.r1  = AW'(r1);
        r.r2  = AW'(r2);
        r.u1  = 1'(u1);
        r.u2  = 1'(u2);
        r.rdy = 1'(rdy);
        r.f1  = FW'(f1);
        r.f2  = FW'(f2);
        return r;
    endfunction

    task automatic present(input vec_t x, input bit push);
        in_valid    = x.v;
        in_data     = x.d;
        in_rd       = x.rd;
        in_rd_used  = x.rdu;
        in_is_load  = x.ld;
        in_rs1      = x.r1;
        in_rs2      = x.r2;
        in_rs1_used = x.u1;
        in_rs2_used = x.u2;
        @(negedge CLK);
        chk("in_ready", 64'(in_ready), 64'(x.rdy));
        chk("fwd_sel1", 64'(fwd_sel1), 64'(x.f1));
        chk("fwd_sel2", 64'(fwd_sel2), 64'(x.f2));
        if (push && x.v && x.rdy) begin
            sbq.push_back('{x.d, x.rd, x.rdu, cyc});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid    = 1'b0;
        in_rs1      = '0;
        in_rs2      = '0;
        in_rs1_used = 1'b0;
        in_rs2_used = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Writeback monitor: each valid WB entry must be the oldest accepted
    // instruction, arriving S cycles after acceptance.
    always @(negedge CLK) begin
        if (mon_en && wb_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: unexpected wb data %0h",
                         st_data[(S-1)*DW +: DW]);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("wb_data", st_data[(S-1)*DW +: DW], e.data);
                chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                chk("wb_rd_used", 64'(wb_rd_used), 64'(e.rdu));
                chk("wb_latency", 64'(cyc - e.t), 64'(S));
            end
        end
    end

    vec_t tbl[11];

    initial begin
        //          v  data   rd u ld r1 r2 u1 u2 rdy f1 f2
        tbl[0]  = mk(1, 'hA0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0);
        tbl[1]  = mk(1, 'hA1, 2, 1, 0, 3, 4, 1, 1, 1, 0, 0);
        tbl[2]  = mk(1, 'hA2, 3, 1, 0, 1, 2, 1, 1, 1, 2, 1);
        tbl[3]  = mk(1, 'hA3, 4, 1, 0, 1, 3, 1, 1, 1, 3, 1);
        tbl[4]  = mk(1, 'hA4, 9, 1, 0, 1, 2, 1, 1, 1, 4, 3);
        tbl[5]  = mk(1, 'hA5, 6, 1, 0, 4, 0, 1, 1, 1, 2, 0);
        tbl[6]  = mk(1, 'hA6, 5, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        tbl[7]  = mk(1, 'hA7, 7, 1, 0, 5, 6, 1, 1, 0, 0, 2);
        tbl[8]  = mk(1, 'hA7, 7, 1, 0, 5, 6, 1, 1, 1, 2, 3);
        tbl[9]  = mk(1, 'hA9, 0, 1, 0, 7, 0, 1, 1, 1, 1, 0);
        tbl[10] = mk(0, 'hAA, 0, 0, 0, 5, 9, 1, 1, 1, 4, 0);

        RESET       = 1'b0;
        freeze      = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_rd       = '0;
        in_rd_used  = 1'b0;
        in_is_load  = 1'b0;
        in_rs1      = 5'd3;
        in_rs2      = 5'd4;
        in_rs1_used = 1'b1;
        in_rs2_used = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;

        @(negedge CLK);
        chk("rst_st_valid", 64'(st_valid), 64'(0));
        chk("rst_st_data_wb", st_data[(S-1)*DW +: DW], 64'(0));
        chk("rst_wb_valid", 64'(wb_valid), 64'(0));
        chk("rst_wb_rd_used", 64'(wb_rd_used), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_fwd1", 64'(fwd_sel1), 64'(0));
        chk("rst_fwd2", 64'(fwd_sel2), 64'(0));
`ifdef OTTER_PIPE_PERF_EN
        chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
        @(posedge CLK);
        #1;

        // Streaming, forwarding and load-use through the vector table.
        mon_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            present(tbl[i], 1'b1);
        end
        idle(6);
        chk("sb_drain1", 64'(sbq.size()), 64'(0));

        // Forward priority and x0.
        present(mk(1, 'hB0, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0), 1'b1);
        present(mk(1, 'hB1, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0), 1'b1);
        present(mk(1, 'hB2, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0), 1'b1);
        present(mk(0, 'h00, 0, 0, 0, 8, 7, 1, 1, 1, 2, 1), 1'b1);
        present(mk(1, 'hB3, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0), 1'b1);
        present(mk(1, 'hB4, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0), 1'b1);
        present(mk(0, 'h00, 0, 0, 0, 7, 0, 1, 1, 1, 4, 0), 1'b1);
        idle(6);
        chk("sb_drain2", 64'(sbq.size()), 64'(0));

        // Freeze holds every stage.
        mon_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            present(mk(1, 'hF0 + i, 10 + i, 1, 0, 0, 0, 0, 0, 1, 0, 0),
                    1'b0);
        end
        freeze   = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'hF4;
        in_rd    = 5'd14;
        for (int n = 0; n < 3; n++) begin
            @(negedge CLK);
            chk("frz_in_ready", 64'(in_ready), 64'(0));
            @(posedge CLK);
            #1;
            chk("frz_st_valid", 64'(st_valid), 64'hF);
            for (int s = 0; s < S; s++) begin
                chk("frz_data", st_data[s*DW +: DW], 64'hF3 - 64'(s));
            end
        end
`ifdef OTTER_PIPE_PERF_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(3));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(1));
`endif

        // Flush together with freeze: only the two youngest die.
        flush   = 1'b1;
        in_data = 64'hF5;
        @(negedge CLK);
        chk("ffl_in_ready", 64'(in_ready), 64'(0));
        @(posedge CLK);
        #1;
        chk("ffl_st_valid", 64'(st_valid), 64'b1100);
        chk("ffl_s2", st_data[2*DW +: DW], 64'hF1);
        chk("ffl_s3", st_data[3*DW +: DW], 64'hF0);
        flush  = 1'b0;
        freeze = 1'b0;
        idle(1);
        chk("post_ffl_valid", 64'(st_valid), 64'b1000);
        chk("post_ffl_wb", st_data[3*DW +: DW], 64'hF1);

        // Flush without freeze from a full pipeline.
        for (int i = 0; i < 4; i++) begin
            present(mk(1, 'hC0 + i, 16 + i, 1, 0, 0, 0, 0, 0, 1, 0, 0),
                    1'b0);
        end
        chk("refill_valid", 64'(st_valid), 64'hF);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'hC4;
        @(negedge CLK);
        chk("fl_in_ready", 64'(in_ready), 64'(0));
        @(posedge CLK);
        #1;
        flush = 1'b0;
        chk("fl_st_valid", 64'(st_valid), 64'b1100);
        chk("fl_s2", st_data[2*DW +: DW], 64'hC2);
        chk("fl_s3", st_data[3*DW +: DW], 64'hC1);
`ifdef OTTER_PIPE_PERF_EN
        chk("flush_cnt", 64'(flush_cnt), 64'(2));
`endif

        // Reset while entries are in flight.
        for (int i = 0; i < 3; i++) begin
            present(mk(1, 'hD0 + i, 20 + i, 1, 0, 0, 0, 0, 0, 1, 0, 0),
                    1'b0);
        end
        chk("pre_rst_valid", 64'(st_valid), 64'b0111);
        RESET    = 1'b0;
        in_valid = 1'b1;
        in_data  = 64'hD3;
        @(posedge CLK);
        #1;
        chk("mid_rst_valid", 64'(st_valid), 64'(0));
        chk("mid_rst_wb", 64'(wb_valid), 64'(0));
        chk("mid_rst_wb_rdu", 64'(wb_rd_used), 64'(0));
        RESET    = 1'b1;
        in_valid = 1'b0;
        @(negedge CLK);
        chk("mid_rst_ready", 64'(in_ready), 64'(1));
`ifdef OTTER_PIPE_PERF_EN
        chk("mid_rst_stall", 64'(stall_cnt), 64'(0));
        chk("mid_rst_flush", 64'(flush_cnt), 64'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/otter_pipe_track.md
# otter_pipe_track

Parametrised pipeline register chain with scoreboard for the pipelined OTTER core. It replaces the hand-written per-stage registers between decode and writeback with STAGES stages. Each stage carries a valid bit, an opaque payload and destination-register tracking. The block also provides:
- load-use stall insertion,
- branch flush,
- external freeze,
- forwarding-source selection for the decode stage.

## Interface
Parameters:
- STAGES, 4, number of tracked stages after decode (stage 0 = EX, STAGES-1 = WB); legal ≥ 2
- DATA_W, 64, payload width per stage (packed instr_t or similar)
- REG_AW, 5, register-address width
- FLUSH_STAGES, 1, number of youngest stages (0..FLUSH_STAGES-1) killed by flush; legal 0..STAGES

Ports:
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  synchronous, active-low reset
- in_valid  in  1  decode presents an instruction
- in_data  in  DATA_W  payload for the presented instruction
- in_rd  in  REG_AW  destination register
- in_rd_used  in  1  instruction writes rd
- in_is_load  in  1  instruction is a load
- in_rs1, in_rs2  in  REG_AW  source registers
- in_rs1_used, in_rs2_used  in  1  source register is read
- in_ready  out  1  instruction accepted this cycle
- freeze  in  1  hold every stage (e.g. memory busy)
- flush  in  1  branch or jump redirect
- st_valid  out  STAGES  per-stage valid
- st_data  out  STAGES*DATA_W  per-stage payload; stage i at [i*DATA_W +: DATA_W]
- wb_valid, wb_rd, wb_rd_used  out  1/REG_AW/1  last-stage view for regfile write
- fwd_sel1, fwd_sel2  out  $clog2(STAGES+1)  forward source; 0 = regfile, k = stage k-1

## Operation
- Stage entry fields: valid, data, rd, rd_used, is_load.
- Advance condition: freeze=0.
  - On advance, stage i+1 ← stage i.
  - On advance, stage 0 ← the presented instruction, with valid = in_valid & in_ready & ~flush.
  - Otherwise stage 0 receives a bubble: valid=0, data unchanged, rd_used=0.
- Load-use hazard:
  - Condition: in_valid, stage 0 valid & is_load & rd_used & rd≠0, and (in_rs1_used & in_rs1==rd or in_rs2_used & in_rs2==rd).
  - Response: in_ready=0; older stages still advance; a bubble enters stage 0.
- in_ready = ~freeze & ~hazard & ~flush.
- Flush:
  - Stages 0..FLUSH_STAGES-1 become invalid on the next edge, regardless of freeze.
  - The presented instruction is not accepted.
  - Flush does not touch stages ≥ FLUSH_STAGES.
- Forwarding, evaluated separately for rs1 and rs2:
  - Match condition: stage k valid & rd_used & rd==rs & rs≠0.
  - fwd_sel = (youngest matching k) + 1.
  - Stage 0 loads are excluded from matching, because the hazard logic covers them.
  - No match gives 0. Register x0 always gives 0.
- wb_* mirror stage STAGES-1 and are valid-qualified. wb_rd_used=0 when the stage is invalid.
- Priority on any edge: RESET > flush (for flushed stages) > freeze > advance.

## Timing
- Reset values (RESET=0 at an edge):
  - all valid, rd_used and is_load bits 0; data 0.
  - st_valid=0, wb_valid=0, wb_rd_used=0.
  - perf counters 0.
  - in_ready, fwd_sel1 and fwd_sel2 are combinational and evaluate to 1/0/0 with in_valid=0 and freeze=0.
- Reset asserted mid-operation discards all in-flight entries in the same edge.
- Latency: an instruction accepted at edge n is in stage k after edge n+k. wb_valid is high in the cycle after edge n+STAGES-1, with no freeze.
- Each frozen cycle adds one cycle of latency to every entry.
- in_ready, fwd_sel1 and fwd_sel2 are combinational from inputs and stage state. There is no register on these paths.
- Throughput: one instruction per cycle absent hazard, freeze or flush.
- A load-use hazard costs exactly one bubble. On the next cycle the load is in stage 1 and is forwarded (fwd_sel=2).

## Configuration
- OTTER_PIPE_PERF_EN defined adds output ports stall_cnt, bubble_cnt and flush_cnt, each 32 bits, saturating at 0xFFFFFFFF.
  - stall_cnt increments each freeze cycle.
  - bubble_cnt increments each hazard cycle with freeze=0.
  - flush_cnt increments each flush cycle.
- OTTER_PIPE_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset then streaming: RESET low 2 cycles, then 6 back-to-back independent instructions, STAGES=4 → in_ready=1 throughout; each payload reaches wb_valid exactly 4 cycles after acceptance.
- Load-use: load with rd=5 followed by add with rs1=5 → in_ready=0 for 1 cycle with a bubble in stage 0; add accepted next cycle with fwd_sel1=2.
- Forward priority: rd=7 in stages 0 and 2, decode rs2=7 → fwd_sel2=1; with rs2=0 and rd=0 in flight → fwd_sel2=0.
- Flush with freeze: FLUSH_STAGES=2, stages 0..3 valid, flush=freeze=1 for one edge → st_valid=4'b1100; presented instruction not accepted.
- Freeze: freeze high 3 cycles → st_data unchanged; with OTTER_PIPE_PERF_EN, stall_cnt=3.
- Reset mid-stream: RESET low while 3 stages valid → next cycle st_valid=0, wb_valid=0.
